// File: rtl/sr_pulse_driver.sv
// Drives set/reset/enable pulses into an SR storage element, confirms the
// result through q/qn readback, retries on mismatch and reports done/err.

module sr_pulse_driver_chk (
    input logic clk,
    input logic rst,
    input logic s,
    input logic r,
    input logic en,
    input logic done,
    input logic err
);
    a_sr_exclusive: assert property (@(posedge clk) disable iff (rst) !(s && r));
    a_err_with_done: assert property (@(posedge clk) disable iff (rst) err |-> done);
    a_drive_needs_en: assert property (@(posedge clk) disable iff (rst) (s || r) |-> en);
endmodule

module sr_pulse_driver #(
    parameter int PULSE_W   = 2,
    parameter int SETTLE    = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    output logic s,
    output logic r,
    output logic en,
    input  logic q_fb,
    input  logic qn_fb,
    output logic done,
    output logic err,
    output logic cur,
    output logic cur_known
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_W - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [2:0] retry_r, retry_s;
    logic       target_r, target_s;
    logic       cur_r, cur_s;
    logic       known_r, known_s;
    logic       s_r, s_s, r_r, r_s, en_r, en_s;
    logic       done_r, done_s, err_r, err_s;
    logic       req_ready_r, req_ready_s;
    logic       accept_s;
    logic       pass_s;

    // req_ready_r is only ever high in IDLE or REPORT, so it doubles as the accept window
    assign accept_s = req_valid & req_ready_r;
    assign pass_s   = (q_fb == target_r) && (qn_fb == ~target_r);

    // Next-state logic; every output is derived from the next state so it can be registered
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        retry_s  = retry_r;
        target_s = target_r;
        cur_s    = cur_r;
        known_s  = known_r;
        err_s    = 1'b0;

        if (accept_s) begin
            target_s = req_val;
            if (known_r && (req_val == cur_r)) begin
                state_s = ST_REPORT;
            end else begin
                state_s = ST_PULSE;
                cnt_s   = PULSE_LOAD;
                retry_s = 3'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_PULSE: begin
                    if (cnt_r == 4'd0) begin
                        state_s = ST_SETTLE;
                        cnt_s   = SETTLE_LOAD;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == 4'd0) begin
                        state_s = ST_CHECK;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (pass_s) begin
                        cur_s   = target_r;
                        known_s = 1'b1;
                        state_s = ST_REPORT;
                    end else if (retry_r < RETRY_MAX) begin
                        retry_s = retry_r + 3'd1;
                        cnt_s   = PULSE_LOAD;
                        state_s = ST_PULSE;
                    end else begin
                        known_s = 1'b0;
                        err_s   = 1'b1;
                        state_s = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        en_s        = (state_s == ST_PULSE);
        s_s         = en_s & target_s;
        r_s         = en_s & ~target_s;
        done_s      = (state_s == ST_REPORT);
        req_ready_s = (state_s == ST_IDLE) || (state_s == ST_REPORT);
    end

    // State and registered outputs; reset also aborts any pulse in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            retry_r     <= 3'd0;
            target_r    <= 1'b0;
            cur_r       <= 1'b0;
            known_r     <= 1'b0;
            s_r         <= 1'b0;
            r_r         <= 1'b0;
            en_r        <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            retry_r     <= retry_s;
            target_r    <= target_s;
            cur_r       <= cur_s;
            known_r     <= known_s;
            s_r         <= s_s;
            r_r         <= r_s;
            en_r        <= en_s;
            done_r      <= done_s;
            err_r       <= err_s;
            req_ready_r <= req_ready_s;
        end
    end

    assign s         = s_r;
    assign r         = r_r;
    assign en        = en_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cur       = cur_r;
    assign cur_known = known_r;
    assign req_ready = req_ready_r;

    sr_pulse_driver_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .s    (s_r),
        .r    (r_r),
        .en   (en_r),
        .done (done_r),
        .err  (err_r)
    );
endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver: a timing model predicts pulse windows,
// completion edge and result per request; a monitor checks every cycle.

module tb_sr_pulse_driver;
    localparam int PW = 2;
    localparam int ST = 3;
    localparam int MR = 2;
    localparam int L  = PW + ST + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_val = 1'b0;
    logic q_fb = 1'b0;
    logic qn_fb = 1'b1;
    logic req_ready, s, r, en, done, err, cur, cur_known;

    sr_pulse_driver #(.PULSE_W(PW), .SETTLE(ST), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_ready (req_ready),
        .s         (s),
        .r         (r),
        .en        (en),
        .q_fb      (q_fb),
        .qn_fb     (qn_fb),
        .done      (done),
        .err       (err),
        .cur       (cur),
        .cur_known (cur_known)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int d_edge;
        bit err;
        bit cur;
        bit known;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] exp_sre[int];
    bit         exp_rdy[int];
    int         free_edge = 1 << 30;
    bit         cur_m = 1'b0;
    bit         known_m = 1'b0;
    bit         act_full = 1'b0;
    bit         act_t = 1'b0;
    int         act_e0 = 0;
    int         act_k = 0;
    int         act_done = 0;
    bit         last_acc = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
        end
    endtask

    // One clock of stimulus: inputs set here are sampled at the next rising edge (nx)
    task automatic drive_cycle(input bit v, input bit val, input int k, input bit do_rst);
        int   nx;
        int   n;
        int   dn;
        int   m;
        bit   fail;
        exp_t keep[$];
        int   keys[$];
        @(posedge clk);
        #1;
        nx = edge_cnt + 1;
        exp_rdy[edge_cnt] = (nx >= free_edge);
        last_acc  = 1'b0;
        rst       = do_rst;
        req_valid = v;
        req_val   = val;
        if (do_rst) begin
            foreach (exp_q[i]) if (exp_q[i].d_edge < nx) keep.push_back(exp_q[i]);
            exp_q = keep;
            foreach (exp_sre[key]) if (key >= nx) keys.push_back(key);
            foreach (keys[i]) exp_sre.delete(keys[i]);
            free_edge = nx + 2;
            cur_m     = 1'b0;
            known_m   = 1'b0;
            act_full  = 1'b0;
        end else if (v && nx >= free_edge) begin
            last_acc = 1'b1;
            if (known_m && val == cur_m) begin
                exp_q.push_back('{nx, 1'b0, cur_m, known_m});
                free_edge = nx + 1;
                act_full  = 1'b0;
            end else begin
                fail = (k > MR);
                n    = fail ? MR + 1 : k + 1;
                for (int a = 0; a < n; a++)
                    for (int j = 0; j < PW; j++)
                        exp_sre[nx + a * L + j] = {val, ~val, 1'b1};
                dn = nx + n * L;
                if (fail) known_m = 1'b0;
                else begin
                    cur_m   = val;
                    known_m = 1'b1;
                end
                exp_q.push_back('{dn, fail, cur_m, known_m});
                free_edge = dn + 1;
                act_full  = 1'b1;
                act_e0    = nx;
                act_k     = k;
                act_t     = val;
                act_done  = dn;
            end
        end
        // Feedback is wrong up to and including the act_k-th check, correct afterwards
        if (act_full && nx <= act_done && (nx - act_e0) <= act_k * L) begin
            m = $urandom_range(0, 2);
            if (m == 0) begin
                q_fb  = ~act_t;
                qn_fb = act_t;
            end else if (m == 1) begin
                q_fb  = 1'b0;
                qn_fb = 1'b0;
            end else begin
                q_fb  = 1'b1;
                qn_fb = 1'b1;
            end
        end else if (act_full) begin
            q_fb  = act_t;
            qn_fb = ~act_t;
        end else begin
            q_fb  = 1'($urandom_range(0, 1));
            qn_fb = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input bit val, input int k);
        for (int g = 0; g < 200; g++) begin
            drive_cycle(1'b1, val, k, 1'b0);
            if (last_acc) break;
        end
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 500; g++) begin
            if (edge_cnt + 1 >= free_edge) break;
            drive_cycle(1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    // Monitor: compares outputs registered at the last rising edge
    initial begin : monitor
        int         e;
        logic [2:0] exp3;
        exp_t       x;
        forever begin
            @(negedge clk);
            if (edge_cnt > 0) begin
                e    = edge_cnt;
                exp3 = exp_sre.exists(e) ? exp_sre[e] : 3'b000;
                check("s_r_en", {29'd0, s, r, en}, {29'd0, exp3});
                if (exp_rdy.exists(e)) check("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy[e]});
                check("err_implies_done", {31'd0, err & ~done}, 32'd0);
                while (exp_q.size() > 0 && exp_q[0].d_edge < e) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_missing: expected done at edge %0d, none by edge %0d", exp_q[0].d_edge, e);
                    void'(exp_q.pop_front());
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done at edge %0d: got done=1, expected done=0", e);
                    end else begin
                        x = exp_q.pop_front();
                        check("done_edge", e, x.d_edge);
                        check("err", {31'd0, err}, {31'd0, x.err});
                        check("cur", {31'd0, cur}, {31'd0, x.cur});
                        check("cur_known", {31'd0, cur_known}, {31'd0, x.known});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : stimulus
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 0, 1'b0);

        send(1'b1, 0);
        wait_idle();
        send(1'b1, 0);
        wait_idle();
        send(1'b0, MR + 1);
        wait_idle();
        send(1'b0, 1);
        wait_idle();

        // Abort during the settle window
        send(1'b1, 0);
        drive_cycle(1'b0, 1'b0, 0, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 80; i++)
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, MR + 1), 1'b0);

        for (int i = 0; i < 700; i++)
            drive_cycle($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, MR + 1), $urandom_range(0, 149) == 0);

        wait_idle();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
